// File: rtl/iq_pkg.sv
// rtl/iq_pkg.sv - shared issue-queue sizing, entry address type and popcount helper
package iq_pkg;

    localparam int DECODE_NUM = 4;
    localparam int ISSUE_NUM  = 4;
    localparam int CIQ_DEPTH  = 16;
    localparam int ADDR_W     = 4;
    localparam int SLOT_IDX_W = $clog2(DECODE_NUM);
    localparam int SLOT_CNT_W = $clog2(DECODE_NUM + 1);

    typedef logic [ADDR_W-1:0] entry_addr_t;
    typedef logic [ADDR_W:0]   entry_cnt_t;

    function automatic entry_cnt_t popcount(input logic [CIQ_DEPTH-1:0] v);
        entry_cnt_t cnt;
        cnt = '0;
        for (int i = 0; i < CIQ_DEPTH; i++) begin
            cnt = cnt + entry_cnt_t'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/iq_free_pick.sv
// rtl/iq_free_pick.sv - picks the DECODE_NUM lowest-index free entries
module iq_free_pick
    import iq_pkg::*;
(
    input  logic [CIQ_DEPTH-1:0]                free_mask,
    output entry_addr_t [DECODE_NUM-1:0]        pick_addr,
    output logic        [DECODE_NUM-1:0]        pick_found
);

    logic [CIQ_DEPTH-1:0] w_rem;

    // Each stage is a first-one finder over what the earlier stages left behind.
    always_comb begin
        w_rem      = free_mask;
        pick_addr  = '0;
        pick_found = '0;
        for (int k = 0; k < DECODE_NUM; k++) begin
            for (int i = CIQ_DEPTH - 1; i >= 0; i--) begin
                if (w_rem[i]) begin
                    pick_addr[k]  = entry_addr_t'(i);
                    pick_found[k] = 1'b1;
                end
            end
            if (pick_found[k]) begin
                w_rem[pick_addr[k]] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/iq_alloc.sv
// rtl/iq_alloc.sv - issue-queue entry allocator with all-or-nothing dispatch and grant release
module iq_alloc
    import iq_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [DECODE_NUM-1:0]           dispatch_valid,
    output logic                            dispatch_ready,
    output entry_addr_t [DECODE_NUM-1:0]    free_addr,
    output logic [DECODE_NUM-1:0]           free_valid,
    input  entry_addr_t [ISSUE_NUM-1:0]     arbit_addr,
    input  logic [ISSUE_NUM-1:0]            arbit_grant,
    input  logic                            flush,
    output logic [CIQ_DEPTH-1:0]            busy_vec,
    output logic [ADDR_W:0]                 free_count,
    output logic                            full
);

    logic [CIQ_DEPTH-1:0]           r_busy_vec;
    entry_cnt_t                     r_free_count;

    entry_addr_t [DECODE_NUM-1:0]   w_pick_addr;
    logic [DECODE_NUM-1:0]          w_pick_found;
    entry_addr_t [DECODE_NUM-1:0]   w_free_addr;
    logic [SLOT_CNT_W-1:0]          w_slot_cnt;
    entry_cnt_t                     w_req_cnt;
    logic                           w_ready;
    logic [DECODE_NUM-1:0]          w_free_valid;
    logic [CIQ_DEPTH-1:0]           w_rel_mask;
    logic [CIQ_DEPTH-1:0]           w_eff_rel;
    logic [CIQ_DEPTH-1:0]           w_alloc_mask;
    logic [CIQ_DEPTH-1:0]           w_busy_next;
    entry_cnt_t                     w_count_next;

    iq_free_pick u_free_pick (
        .free_mask  (~r_busy_vec),
        .pick_addr  (w_pick_addr),
        .pick_found (w_pick_found)
    );

    // Compact the picks onto the valid slots so sparse groups still use the lowest free entries.
    always_comb begin
        w_free_addr = '0;
        w_slot_cnt  = '0;
        for (int i = 0; i < DECODE_NUM; i++) begin
            if (dispatch_valid[i]) begin
                w_free_addr[i] = w_pick_addr[w_slot_cnt[SLOT_IDX_W-1:0]];
                w_slot_cnt     = w_slot_cnt + SLOT_CNT_W'(1);
            end
        end
    end

    assign w_req_cnt    = popcount(CIQ_DEPTH'(dispatch_valid));
    assign w_ready      = !flush && (w_req_cnt <= r_free_count);
    assign w_free_valid = dispatch_valid & {DECODE_NUM{w_ready}};

    always_comb begin
        w_rel_mask = '0;
        for (int j = 0; j < ISSUE_NUM; j++) begin
            if (arbit_grant[j]) begin
                w_rel_mask[arbit_addr[j]] = 1'b1;
            end
        end
    end

    always_comb begin
        w_alloc_mask = '0;
        for (int i = 0; i < DECODE_NUM; i++) begin
            if (w_free_valid[i]) begin
                w_alloc_mask[w_free_addr[i]] = 1'b1;
            end
        end
    end

    // Only grants that hit occupied entries give anything back to the free pool.
    assign w_eff_rel    = w_rel_mask & r_busy_vec;
    assign w_busy_next  = (r_busy_vec & ~w_rel_mask) | w_alloc_mask;
    assign w_count_next = r_free_count + popcount(w_eff_rel) - popcount(w_alloc_mask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy_vec   <= '0;
            r_free_count <= entry_cnt_t'(CIQ_DEPTH);
        end else if (flush) begin
            r_busy_vec   <= '0;
            r_free_count <= entry_cnt_t'(CIQ_DEPTH);
        end else begin
            r_busy_vec   <= w_busy_next;
            r_free_count <= w_count_next;
        end
    end

    assign dispatch_ready = w_ready;
    assign free_addr      = w_free_addr;
    assign free_valid     = w_free_valid;
    assign busy_vec       = r_busy_vec;
    assign free_count     = r_free_count;
    assign full           = (r_free_count == '0);

`ifndef SYNTHESIS
    a_alloc_from_free: assert property (@(posedge clk) disable iff (!rst_n)
        (w_alloc_mask & r_busy_vec) == '0);
    a_alloc_rel_disjoint: assert property (@(posedge clk) disable iff (!rst_n)
        (w_alloc_mask & w_eff_rel) == '0);
    a_idle_grant_no_effect: assert property (@(posedge clk) disable iff (!rst_n)
        ((w_busy_next & ~w_alloc_mask) == (r_busy_vec & ~w_eff_rel)));
    a_count_tracks_busy: assert property (@(posedge clk) disable iff (!rst_n)
        r_free_count == entry_cnt_t'(CIQ_DEPTH) - popcount(r_busy_vec));
    a_picks_cover_group: assert property (@(posedge clk) disable iff (!rst_n)
        !w_ready || (popcount(CIQ_DEPTH'(w_pick_found)) >= w_req_cnt));
`endif

endmodule

// File: tb/tb_iq_alloc.sv
// tb/tb_iq_alloc.sv - directed self-checking bench for iq_alloc
module tb_iq_alloc;
    import iq_pkg::*;

    logic                           clk;
    logic                           rst_n;
    logic [DECODE_NUM-1:0]          dispatch_valid;
    logic                           dispatch_ready;
    entry_addr_t [DECODE_NUM-1:0]   free_addr;
    logic [DECODE_NUM-1:0]          free_valid;
    entry_addr_t [ISSUE_NUM-1:0]    arbit_addr;
    logic [ISSUE_NUM-1:0]           arbit_grant;
    logic                           flush;
    logic [CIQ_DEPTH-1:0]           busy_vec;
    logic [ADDR_W:0]                free_count;
    logic                           full;

    int n_checks = 0;
    int n_errors = 0;

    iq_alloc dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .dispatch_valid (dispatch_valid),
        .dispatch_ready (dispatch_ready),
        .free_addr      (free_addr),
        .free_valid     (free_valid),
        .arbit_addr     (arbit_addr),
        .arbit_grant    (arbit_grant),
        .flush          (flush),
        .busy_vec       (busy_vec),
        .free_count     (free_count),
        .full           (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        dispatch_valid = '0;
        arbit_grant    = '0;
        arbit_addr     = '0;
        flush          = 1'b0;
    endtask

    task automatic check_state(input string tag, input logic [15:0] exp_busy, input logic [4:0] exp_cnt);
        check({tag, ".busy"}, 32'(busy_vec), 32'(exp_busy));
        check({tag, ".count"}, 32'(free_count), 32'(exp_cnt));
        check({tag, ".full"}, 32'(full), 32'(exp_cnt == 5'd0));
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        #12;
        check_state("reset", 16'h0000, 5'd16);
        check("reset.ready", 32'(dispatch_ready), 32'd1);
        rst_n = 1'b1;
        step();

        // 1: full group into an empty queue
        dispatch_valid = 4'b1111;
        #1;
        check("t1.addr", 32'(free_addr), 32'h3210);
        check("t1.valid", 32'(free_valid), 32'hF);
        check("t1.ready", 32'(dispatch_ready), 32'd1);
        step();
        idle_inputs();
        check_state("t1", 16'h000F, 5'd12);

        // release 1,3 while allocating 4..7 to reach 00F5
        dispatch_valid = 4'b1111;
        arbit_grant    = 4'b0011;
        arbit_addr     = {4'd0, 4'd0, 4'd3, 4'd1};
        #1;
        check("t2pre.addr", 32'(free_addr), 32'h7654);
        step();
        idle_inputs();
        check_state("t2pre", 16'h00F5, 5'd10);

        // 2: sparse group fills the holes
        dispatch_valid = 4'b1010;
        #1;
        check("t2.addr", 32'(free_addr), 32'h3010);
        check("t2.valid", 32'(free_valid), 32'hA);
        step();
        idle_inputs();
        check_state("t2", 16'h00FF, 5'd8);

        dispatch_valid = 4'b1111;
        step();
        dispatch_valid = 4'b1100;
        #1;
        check("t3pre.addr", 32'(free_addr), 32'hDC00);
        step();
        idle_inputs();
        check_state("t3pre", 16'h3FFF, 5'd2);

        // 3: group of three does not fit in two
        dispatch_valid = 4'b0111;
        #1;
        check("t3.ready", 32'(dispatch_ready), 32'd0);
        check("t3.valid", 32'(free_valid), 32'h0);
        step();
        check_state("t3hold", 16'h3FFF, 5'd2);
        arbit_grant = 4'b0011;
        arbit_addr  = {4'd0, 4'd0, 4'd9, 4'd5};
        #1;
        check("t3.nobypass", 32'(dispatch_ready), 32'd0);
        step();
        arbit_grant = '0;
        check_state("t3rel", 16'h3DDF, 5'd4);
        #1;
        check("t3.accept", 32'(dispatch_ready), 32'd1);
        check("t3.addr", 32'(free_addr), 32'h0E95);
        step();
        idle_inputs();
        check_state("t3", 16'h7FFF, 5'd1);

        dispatch_valid = 4'b0001;
        #1;
        check("t4pre.addr", 32'(free_addr), 32'h000F);
        step();
        idle_inputs();
        check_state("t4pre", 16'hFFFF, 5'd0);

        // 4: duplicate grant on a full queue
        dispatch_valid = 4'b0001;
        arbit_grant    = 4'b0011;
        arbit_addr     = {4'd0, 4'd0, 4'd7, 4'd7};
        #1;
        check("t4.ready", 32'(dispatch_ready), 32'd0);
        check("t4.valid", 32'(free_valid), 32'h0);
        step();
        idle_inputs();
        check_state("t4", 16'hFF7F, 5'd1);

        dispatch_valid = 4'b0001;
        #1;
        check("t5pre.addr", 32'(free_addr), 32'h0007);
        step();
        idle_inputs();
        check_state("t5pre", 16'hFFFF, 5'd0);

        // 5: flush wins over grants and dispatch
        flush          = 1'b1;
        dispatch_valid = 4'b1111;
        arbit_grant    = 4'b0011;
        arbit_addr     = {4'd0, 4'd0, 4'd1, 4'd0};
        #1;
        check("t5.ready", 32'(dispatch_ready), 32'd0);
        check("t5.valid", 32'(free_valid), 32'h0);
        step();
        idle_inputs();
        check_state("t5", 16'h0000, 5'd16);

        for (int i = 0; i < 4; i++) begin
            dispatch_valid = 4'b1111;
            step();
        end
        idle_inputs();
        check_state("t6pre", 16'hFFFF, 5'd0);

        // 6: asynchronous reset between edges
        #1;
        rst_n = 1'b0;
        #1;
        check_state("t6", 16'h0000, 5'd16);
        check("t6.ready", 32'(dispatch_ready), 32'd1);
        rst_n = 1'b1;
        step();
        check_state("t6post", 16'h0000, 5'd16);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/iq_alloc.md
Name: iq_alloc

Overview:
- Allocation stage directly upstream of the centralized issue queue (CIQ).
- Tracks which CIQ entries are occupied and assigns free entry addresses to up to DECODE_NUM renamed instructions per cycle.
- Drives the queue's free_addr/free_valid write ports.
- Reclaims entries when the arbiter grants them for issue.
- Back-pressures rename when the whole dispatch group does not fit.

Parameters:
- DECODE_NUM, 4, instructions presented by rename per cycle
- ISSUE_NUM, 4, arbiter grants per cycle
- CIQ_DEPTH, 16, issue queue entries
- ADDR_W, 4, entry address width, equal to log2(CIQ_DEPTH)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous assert, active-low
- dispatch_valid  in  DECODE_NUM  per-slot valid from rename; may be sparse
- dispatch_ready  out  1  whole group accepted this cycle
- free_addr  out  DECODE_NUM x ADDR_W  CIQ entry assigned to each slot
- free_valid  out  DECODE_NUM  slot i writes the CIQ at free_addr[i] at the next edge
- arbit_addr  in  ISSUE_NUM x ADDR_W  granted entry addresses
- arbit_grant  in  ISSUE_NUM  per-lane grant valid
- flush  in  1  pipeline flush; empties the queue
- busy_vec  out  CIQ_DEPTH  registered occupancy, bit i = entry i holds an instruction
- free_count  out  ADDR_W+1  registered count of free entries, range 0..CIQ_DEPTH
- full  out  1  free_count == 0

Behaviour:
- Reset values (rst_n low, async):
  - busy_vec = 0, free_count = CIQ_DEPTH, full = 0.
  - Combinational outputs follow from these values.
- State: busy_vec register and free_count register. free_count must always equal CIQ_DEPTH minus popcount(busy_vec).
- Selection (combinational, from current busy_vec only):
  - Let F0 < F1 < ... be the indices of clear bits in busy_vec.
  - The k-th set bit of dispatch_valid, counted from slot 0, gets free_addr = Fk.
  - Slots with dispatch_valid=0 drive free_addr = 0.
- Acceptance is all-or-nothing:
  - dispatch_ready = !flush && (popcount(dispatch_valid) <= free_count).
  - free_valid[i] = dispatch_valid[i] && dispatch_ready.
  - dispatch_ready is 1 when dispatch_valid is all zero (and flush=0).
- Latency:
  - Address and valid are produced in the same cycle as dispatch_valid.
  - The CIQ captures the instruction at the next edge.
  - busy_vec sets for those entries at the same edge.
- Release:
  - rel_mask = OR over lanes j with arbit_grant[j] of onehot(arbit_addr[j]).
  - Released entries clear at the next edge and are first allocatable in the following cycle. There is no same-cycle bypass.
- Update rule: busy_next = (busy_vec & ~rel_mask) | alloc_mask.
  - free_count_next = free_count + popcount(rel_mask & busy_vec) - popcount(alloc_mask).
  - Duplicate grant addresses count once.
- Grant to a non-busy entry: no effect on state. Covered by a simulation assertion.
- Alloc and release never hit the same entry in one cycle, because allocation draws only from clear bits. Covered by an assertion.
- Flush: busy_next = 0 and free_count_next = CIQ_DEPTH. Allocation and release in that cycle are discarded, since free_valid is forced 0.
- Full: dispatch_ready = 0 for any nonzero dispatch_valid; grants still release entries.
- Reset asserted mid-operation: state clears immediately, without waiting for an edge. Outputs recompute from the reset values.

Decomposition:
- Shared package iq_pkg holds CIQ_DEPTH, ADDR_W, DECODE_NUM, ISSUE_NUM and the entry-address typedef. iq_alloc and issue_queue both import it.
- One sub-module: iq_free_pick.
  - Combinational.
  - Input: free mask. Outputs: DECODE_NUM lowest-index free addresses plus per-pick found flags.
  - Implemented as chained first-one finders, each masking the previous pick.
- The popcount helper is a package function.

Test Plan:
1. Reset, then dispatch_valid=4'b1111 → free_addr=0,1,2,3, free_valid=1111, dispatch_ready=1; next cycle busy_vec=16'h000F, free_count=12.
2. busy_vec=16'h00F5, dispatch_valid=4'b1010 → slot1 gets addr 1, slot3 gets addr 3, slots 0 and 2 not valid; next cycle busy_vec=16'h00FF, free_count=8.
3. free_count=2, dispatch_valid=4'b0111 → dispatch_ready=0, free_valid=0, state unchanged; after grants free entries 5 and 9, the next cycle accepts the group.
4. Queue full; arbit_grant=4'b0011 with arbit_addr=7,7 → entry 7 frees once, free_count=1 next cycle; the same-cycle dispatch is still refused.
5. Full queue with flush=1 and simultaneous grants and dispatch → busy_vec=0, free_count=16 next cycle, free_valid=0 during the flush cycle.
6. rst_n pulsed low between edges with busy_vec=16'hFFFF → busy_vec=0 and full=0 before the next clk edge.
